fb_writer: RTL and testbench
============================

# fb_writer

Framebuffer write engine: the producer side of the 4096 × 8-bit pixel framebuffer that `vga` scans out. It accepts drawing commands over a valid/ready handshake and emits one framebuffer write per clock. Supported commands are single pixel, filled rectangle and full-screen clear. Its write port drives port A of the dual-port framebuffer RAM; `vga` reads port B.

## Interface
Parameters:
- `FB_W`, 64: framebuffer columns (power of two).
- `FB_H`, 64: framebuffer rows.
- `AW`, 12: address width, equal to log2(FB_W·FB_H).

Ports:
- `clock`  in  1: single clock, the same domain as the framebuffer write port.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: engine idle, so a command can be accepted.
- `cmd_op`  in  2: 0 = PIXEL, 1 = FILL, 2 = CLEAR, 3 = reserved.
- `cmd_x0`, `cmd_y0`  in  6 each: start corner, or the pixel coordinate for PIXEL.
- `cmd_x1`, `cmd_y1`  in  6 each: inclusive end corner (FILL only).
- `cmd_color`  in  8: pixel value (PIXEL and FILL).
- `wr_en`  out  1: framebuffer write strobe.
- `wr_addr`  out  AW: write address, equal to y·FB_W + x.
- `wr_data`  out  8: write data.
- `busy`  out  1: a command is in progress; this is the inverse of `cmd_ready`.
- `cmd_err`  out  1: one-cycle pulse when a command is rejected.

## Operation
- FSM has two states, IDLE and WRITE. `cmd_ready` = (state == IDLE).
- **Accept:** a command is accepted on the edge where `cmd_valid && cmd_ready`. Operands are latched into internal registers; input changes after acceptance are ignored.
- **PIXEL:** one write, `wr_addr` = {y0, x0}, `wr_data` = `cmd_color`.
- **FILL:** writes cover x0..x1 × y0..y1 in raster order: x increments first; when x reaches x1 it wraps to x0 and y increments. Write count is (x1−x0+1)·(y1−y0+1).
- **CLEAR:** equivalent to FILL over 0..FB_W−1 × 0..FB_H−1 with color 0x00, giving 4096 writes. Its x and y operands are ignored.
- **Rejection:** a FILL with x1 < x0 or y1 < y0, or any op = 3, is still accepted, but:
  - `cmd_err` pulses for one cycle on the following cycle;
  - no writes occur;
  - the state stays IDLE.
- **Address arithmetic:** `wr_addr` = {y[5:0], x[5:0]} (concatenation, no multiplier). x and y counters are 6 bits. The end test compares against the latched x1/y1, never against counter overflow.
- **Completion:** on the last write, state returns to IDLE on the same edge that deasserts `wr_en`.
- **Reset mid-operation:** the command is aborted and the remaining writes are dropped. In the cycle after the reset edge, `wr_en` = 0 and `cmd_ready` = 1.
- **Reset values:**
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0;
  - `cmd_err` = 0;
  - state = IDLE, so `cmd_ready` = 1 and `busy` = 0.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from the state register.
- A command accepted at edge N produces its first `wr_en` in cycle N+1, i.e. visible after edge N.
- A command of k writes holds `wr_en` high for k consecutive cycles (N+1 .. N+k) with no bubbles.
- `cmd_ready` is low for cycles N+1 .. N+k and high again in cycle N+k+1.
- Back-to-back commands therefore leave exactly one idle write cycle between them.
- `cmd_err` is high in cycle N+1 only. `cmd_ready` stays high throughout a rejection, so a new command can be accepted at edge N+1.
- While `cmd_ready` = 0, `cmd_valid` is ignored; the producer must hold the command until it is accepted.
- Port A writes have no read-back hazards; the RAM handles port collisions with `vga`.

## Structure
- Package `gpu_pkg` holds:
  - the opcode constants `OP_PIXEL`, `OP_FILL`, `OP_CLEAR`;
  - `FB_W`, `FB_H`, `FB_AW`, `PIX_W` = 8, shared with `vga` and the framebuffer RAM wrapper.
- Sub-module `fb_raster_counter`: 2-D x/y counter with latched bounds, `start`, `step`, `last` and `{y,x}` outputs. It is also reusable for future blit operations.
- `fb_writer` contains the FSM, operand latches, validation and output registers.

## Test plan
- **Reset values:** assert `reset` for 2 cycles → `wr_en` = 0, `wr_addr` = 0, `cmd_ready` = 1, `cmd_err` = 0.
- **PIXEL:** PIXEL (x0 = 5, y0 = 3, color = 0xA5) → one `wr_en` cycle with `wr_addr` = 0x0C5 and `wr_data` = 0xA5; `cmd_ready` is low for exactly 1 cycle.
- **FILL:** FILL (2,1)–(4,2), color 0x3C → 6 consecutive writes at addresses 0x042, 0x043, 0x044, 0x082, 0x083, 0x084, all with data 0x3C.
- **Back-to-back:** CLEAR immediately followed by a held PIXEL (63,63,0xFF) →
  - 4096 writes of 0x00, addresses 0x000..0xFFF in order;
  - one idle cycle;
  - then a single write of 0xFF at 0xFFF.
- **Rejection:** FILL (10,0)–(9,0), then op = 3 → `cmd_err` pulses once per command, with zero writes and `cmd_ready` never dropping.
- **Reset mid-command:** assert `reset` during the 20th write of a CLEAR → `wr_en` = 0 in the next cycle and no further writes. A subsequent PIXEL is accepted normally with the standard 1-cycle latency.

Source files
------------

// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg : framebuffer geometry and drawing opcodes shared by the GPU blocks
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package gpu_pkg;

  localparam int FB_W    = 64;
  localparam int FB_H    = 64;
  localparam int FB_AW   = 12;
  localparam int PIX_W   = 8;
  localparam int COORD_W = 6;

  localparam logic [1:0] OP_PIXEL = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fb_raster_counter.sv
// ---------------------------------------------------------------------------
// fb_raster_counter : 2-D raster x/y walker over latched inclusive bounds
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fb_raster_counter #(
  parameter int CW = 6
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [CW-1:0]   x0_i,
  input  logic [CW-1:0]   y0_i,
  input  logic [CW-1:0]   x1_i,
  input  logic [CW-1:0]   y1_i,
  output logic            last_o,
  output logic [2*CW-1:0] xy_o
);

  logic [CW-1:0] x_q, y_q;
  logic [CW-1:0] x0_q, x1_q, y1_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else if (start_i) begin
      x_q  <= x0_i;
      y_q  <= y0_i;
      x0_q <= x0_i;
      x1_q <= x1_i;
      y1_q <= y1_i;
    end else if (step_i) begin
      // End of row is detected against the latched bound, not by wrap-around
      if (x_q == x1_q) begin
        x_q <= x0_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign last_o = (x_q == x1_q) && (y_q == y1_q);
  assign xy_o   = {y_q, x_q};

endmodule

`default_nettype wire

// File: rtl/fb_writer.sv
// ---------------------------------------------------------------------------
// fb_writer : framebuffer write engine for PIXEL / FILL / CLEAR commands
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fb_writer #(
  parameter int FB_W = 64,
  parameter int FB_H = 64,
  parameter int AW   = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [5:0]    cmd_x0,
  input  logic [5:0]    cmd_y0,
  input  logic [5:0]    cmd_x1,
  input  logic [5:0]    cmd_y1,
  input  logic [7:0]    cmd_color,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          cmd_err
);

  import gpu_pkg::*;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(FB_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(FB_H - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t             state_q;
  logic               wr_en_q;
  logic [PIX_W-1:0]   wr_data_q;
  logic               cmd_err_q;

  logic               accept_d, bad_d, start_d, step_d, last_d;
  logic [COORD_W-1:0] bx0_d, by0_d, bx1_d, by1_d;
  logic [AW-1:0]      xy_d;

  assign accept_d = cmd_valid && (state_q == S_IDLE);
  assign bad_d    = (cmd_op == 2'd3) ||
                    ((cmd_op == OP_FILL) && ((cmd_x1 < cmd_x0) || (cmd_y1 < cmd_y0)));
  assign start_d  = accept_d && !bad_d;
  assign step_d   = (state_q == S_WRITE) && !last_d;

  always_comb begin
    bx0_d = cmd_x0;
    by0_d = cmd_y0;
    bx1_d = cmd_x0;
    by1_d = cmd_y0;
    case (cmd_op)
      OP_FILL: begin
        bx1_d = cmd_x1;
        by1_d = cmd_y1;
      end
      OP_CLEAR: begin
        bx0_d = '0;
        by0_d = '0;
        bx1_d = X_MAX;
        by1_d = Y_MAX;
      end
      default: ;
    endcase
  end

  fb_raster_counter #(.CW(COORD_W)) u_raster (
    .clock_i (clock),
    .reset_i (reset),
    .start_i (start_d),
    .step_i  (step_d),
    .x0_i    (bx0_d),
    .y0_i    (by0_d),
    .x1_i    (bx1_d),
    .y1_i    (by1_d),
    .last_o  (last_d),
    .xy_o    (xy_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= accept_d && bad_d;
      case (state_q)
        S_IDLE: begin
          wr_en_q <= 1'b0;
          if (start_d) begin
            state_q   <= S_WRITE;
            wr_en_q   <= 1'b1;
            wr_data_q <= (cmd_op == OP_CLEAR) ? '0 : cmd_color;
          end
        end
        S_WRITE: begin
          if (last_d) begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Address comes straight from the counter's registered {y,x}
  assign wr_addr   = xy_d;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign cmd_err   = cmd_err_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_writer : directed self-checking bench for fb_writer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fb_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [7:0]  cmd_color = '0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        cmd_err;

  fb_writer #(.FB_W(64), .FB_H(64), .AW(12)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;
  int err_cnt  = 0;
  int unsigned wq_addr[$];
  int unsigned wq_data[$];
  int          wq_cyc[$];

  always @(negedge clock) begin
    cyc++;
    if (wr_en === 1'b1) begin
      wq_addr.push_back(32'(wr_addr));
      wq_data.push_back(32'(wr_data));
      wq_cyc.push_back(cyc);
    end
    if (cmd_ready !== 1'b1) busy_cnt++;
    if (cmd_err === 1'b1)   err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    busy_cnt = 0;
    err_cnt  = 0;
  endtask

  // Present a command at a falling edge and hold it until the engine takes it
  task automatic send(input logic [1:0] op, input logic [5:0] x0, input logic [5:0] y0,
                      input logic [5:0] x1, input logic [5:0] y1, input logic [7:0] color);
    int w;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_color = color;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 5000) begin
      @(negedge clock);
      w++;
    end
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_x0    = 6'h2A;
    cmd_color = 8'hEE;
  endtask

  logic [11:0] fill_exp [6] = '{12'h042, 12'h043, 12'h044, 12'h082, 12'h083, 12'h084};

  initial begin
    int bad;

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wr_en",     32'(wr_en),     32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cmd_err",   32'(cmd_err),   32'd0);
    reset = 1'b0;

    // PIXEL (5,3) 0xA5
    clear_log();
    send(2'd0, 6'd5, 6'd3, 6'd0, 6'd0, 8'hA5);
    @(negedge clock);
    check("px_wr_en",   32'(wr_en),     32'd1);
    check("px_ready",   32'(cmd_ready), 32'd0);
    check("px_busy",    32'(busy),      32'd1);
    check("px_addr",    32'(wr_addr),   32'h0C5);
    check("px_data",    32'(wr_data),   32'hA5);
    @(negedge clock);
    check("px_wr_en_done", 32'(wr_en),     32'd0);
    check("px_ready_done", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clock);
    check("px_count",    32'(wq_addr.size()), 32'd1);
    check("px_busy_cyc", 32'(busy_cnt),       32'd1);

    // FILL (2,1)-(4,2) 0x3C
    clear_log();
    send(2'd1, 6'd2, 6'd1, 6'd4, 6'd2, 8'h3C);
    repeat (10) @(negedge clock);
    check("fill_count",    32'(wq_addr.size()), 32'd6);
    check("fill_busy_cyc", 32'(busy_cnt),       32'd6);
    if (wq_addr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("fill_addr%0d", i), wq_addr[i], 32'(fill_exp[i]));
        check($sformatf("fill_data%0d", i), wq_data[i], 32'h3C);
      end
      check("fill_contig", 32'(wq_cyc[5] - wq_cyc[0]), 32'd5);
    end

    // CLEAR then a held PIXEL (63,63,0xFF)
    clear_log();
    send(2'd2, 6'd7, 6'd7, 6'd1, 6'd1, 8'h55);
    send(2'd0, 6'd63, 6'd63, 6'd0, 6'd0, 8'hFF);
    repeat (5) @(negedge clock);
    check("b2b_count",    32'(wq_addr.size()), 32'd4097);
    check("b2b_busy_cyc", 32'(busy_cnt),       32'd4097);
    if (wq_addr.size() == 4097) begin
      bad = 0;
      for (int i = 0; i < 4096; i++)
        if (wq_addr[i] != 32'(i) || wq_data[i] != 32'd0) bad++;
      check("clr_seq_errors", 32'(bad),       32'd0);
      check("b2b_px_addr",    wq_addr[4096],  32'hFFF);
      check("b2b_px_data",    wq_data[4096],  32'hFF);
      check("b2b_gap",        32'(wq_cyc[4096] - wq_cyc[4095]), 32'd2);
      check("clr_contig",     32'(wq_cyc[4095] - wq_cyc[0]),    32'd4095);
    end

    // Rejections: inverted FILL, then reserved op
    clear_log();
    send(2'd1, 6'd10, 6'd0, 6'd9, 6'd0, 8'h77);
    @(negedge clock);
    check("rej1_err",   32'(cmd_err),   32'd1);
    check("rej1_ready", 32'(cmd_ready), 32'd1);
    check("rej1_wr_en", 32'(wr_en),     32'd0);
    @(negedge clock);
    check("rej1_err_drop", 32'(cmd_err), 32'd0);
    send(2'd3, 6'd1, 6'd1, 6'd2, 6'd2, 8'h11);
    @(negedge clock);
    check("rej3_err", 32'(cmd_err), 32'd1);
    repeat (5) @(negedge clock);
    check("rej_writes",   32'(wq_addr.size()), 32'd0);
    check("rej_busy_cyc", 32'(busy_cnt),       32'd0);
    check("rej_err_cnt",  32'(err_cnt),        32'd2);

    // Reset during the 20th write of a CLEAR
    clear_log();
    send(2'd2, 6'd0, 6'd0, 6'd0, 6'd0, 8'h00);
    repeat (19) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid_rst_wr_en", 32'(wr_en),     32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_addr",  32'(wr_addr),   32'd0);
    repeat (10) @(negedge clock);
    check("mid_rst_writes", 32'(wq_addr.size()), 32'd20);

    // PIXEL after abort keeps its one-cycle latency
    clear_log();
    send(2'd0, 6'd1, 6'd2, 6'd0, 6'd0, 8'h11);
    @(negedge clock);
    check("post_px_wr_en", 32'(wr_en),   32'd1);
    check("post_px_addr",  32'(wr_addr), 32'h081);
    check("post_px_data",  32'(wr_data), 32'h11);
    repeat (3) @(negedge clock);
    check("post_px_count", 32'(wq_addr.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
